// File: rtl/musa_pkg.sv
// musa_pkg: shared word type, default stack depth and stack request encoding.
package musa_pkg;

    localparam int WORD_W      = 32;
    localparam int STACK_DEPTH = 16;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [2:0] {
        OP_IDLE,
        OP_PUSH,
        OP_DROP,
        OP_POP,
        OP_UNDER,
        OP_REPLACE,
        OP_PASS
    } stack_op_e;

endpackage

// File: rtl/stack_ram.sv
// stack_ram: stack storage with one synchronous write port and one asynchronous read port.
module stack_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]         raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/stack_unit.sv
// stack_unit: LIFO return stack answering decode-stage push/pop requests.
// Pops return data one cycle later; simultaneous push+pop replaces the top entry.
module stack_unit
    import musa_pkg::*;
#(
    parameter int DATA_WIDTH = WORD_W,
    parameter int DEPTH      = STACK_DEPTH,
    parameter int PTR_WIDTH  = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  pop_valid,
    output logic [DATA_WIDTH-1:0] top,
    output logic [PTR_WIDTH-1:0]  count,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [PTR_WIDTH-1:0] FULL_CNT = PTR_WIDTH'(DEPTH);

    stack_op_e             op;
    logic [PTR_WIDTH-1:0]  count_q, count_d, top_ptr;
    logic [DATA_WIDTH-1:0] pop_data_q, pop_data_d, rd_data;
    logic                  pop_valid_q, pop_valid_d;
    logic                  ovf_q, ovf_d, udf_q, udf_d;
    logic                  we;
    logic [AW-1:0]         waddr;

    assign empty   = count_q == '0;
    assign full    = count_q == FULL_CNT;
    assign top_ptr = count_q - 1'b1;
    assign top     = empty ? '0 : rd_data;

    assign count     = count_q;
    assign pop_data  = pop_data_q;
    assign pop_valid = pop_valid_q;
    assign overflow  = ovf_q;
    assign underflow = udf_q;

    always_comb begin
        op = (push && pop) ? (empty ? OP_PASS : OP_REPLACE)
           : push          ? (full ? OP_DROP : OP_PUSH)
           : pop           ? (empty ? OP_UNDER : OP_POP)
           :                 OP_IDLE;
        count_d     = (op == OP_PUSH) ? count_q + 1'b1
                    : (op == OP_POP)  ? count_q - 1'b1
                    :                   count_q;
        pop_valid_d = op inside {OP_POP, OP_REPLACE, OP_PASS};
        pop_data_d  = (op == OP_PASS) ? push_data
                    : pop_valid_d     ? rd_data
                    :                   pop_data_q;
        // a new error event beats a coincident clear
        ovf_d = (op == OP_DROP) || (ovf_q && !clr_err);
        udf_d = (op == OP_UNDER) || (udf_q && !clr_err);
        we    = rst && (op == OP_PUSH || op == OP_REPLACE);
        waddr = (op == OP_REPLACE) ? top_ptr[AW-1:0] : count_q[AW-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q     <= '0;
            pop_data_q  <= '0;
            pop_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
        end else begin
            count_q     <= count_d;
            pop_data_q  <= pop_data_d;
            pop_valid_q <= pop_valid_d;
            ovf_q       <= ovf_d;
            udf_q       <= udf_d;
        end
    end

    stack_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH)
    ) u_ram (
        .clk    (clk),
        .we_i   (we),
        .waddr_i(waddr),
        .wdata_i(push_data),
        .raddr_i(top_ptr[AW-1:0]),
        .rdata_o(rd_data)
    );

endmodule

// File: tb/tb_stack_unit.sv
// tb_stack_unit: table-driven vectors plus a queue-based stack model and pop scoreboard.
module tb_stack_unit;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        push = 1'b0, pop = 1'b0, clr_err = 1'b0;
    logic [31:0] push_data = '0;
    logic [31:0] pop_data, top;
    logic        pop_valid, empty, full, overflow, underflow;
    logic [4:0]  count;

    stack_unit #(.DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .push_data(push_data),
        .clr_err  (clr_err),
        .pop_data (pop_data),
        .pop_valid(pop_valid),
        .top      (top),
        .count    (count),
        .empty    (empty),
        .full     (full),
        .overflow (overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    int          nvec = 0;
    int          nerr = 0;
    logic [31:0] stk[$];
    logic [31:0] sb[$];
    logic        m_ovf = 1'b0, m_udf = 1'b0;
    logic [31:0] m_pd = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic p, input logic q,
                        input logic [31:0] d, input logic c);
        logic        ovf_set, udf_set;
        logic [31:0] exp_pd;
        @(negedge clk);
        rst = r; push = p; pop = q; push_data = d; clr_err = c;
        ovf_set = 1'b0;
        udf_set = 1'b0;
        if (!r) begin
            stk.delete();
            sb.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
            m_pd  = '0;
        end else begin
            if (p && q) begin
                if (stk.size() == 0) m_pd = d;
                else begin
                    m_pd = stk[stk.size()-1];
                    stk[stk.size()-1] = d;
                end
                sb.push_back(m_pd);
            end else if (p) begin
                if (stk.size() == DEPTH) ovf_set = 1'b1;
                else stk.push_back(d);
            end else if (q) begin
                if (stk.size() == 0) udf_set = 1'b1;
                else begin
                    m_pd = stk.pop_back();
                    sb.push_back(m_pd);
                end
            end
            m_ovf = ovf_set | (m_ovf & ~c);
            m_udf = udf_set | (m_udf & ~c);
        end
        @(posedge clk);
        #1;
        if (pop_valid) begin
            if (sb.size() == 0) chk("pop_valid_spurious", 32'(pop_valid), 32'd0);
            else begin
                exp_pd = sb.pop_front();
                chk("sb_pop_data", pop_data, exp_pd);
            end
        end else if (sb.size() != 0) begin
            chk("pop_valid_missing", 32'(pop_valid), 32'd1);
            void'(sb.pop_front());
        end
        chk("pop_data_hold", pop_data, m_pd);
        chk("count", 32'(count), 32'(stk.size()));
        chk("top", top, stk.size() == 0 ? 32'd0 : stk[stk.size()-1]);
        chk("empty", 32'(empty), 32'(stk.size() == 0));
        chk("full", 32'(full), 32'(stk.size() == DEPTH));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_udf));
    endtask

    typedef struct {
        logic        r, p, q, c;
        logic [31:0] d;
        int          e_cnt;
        logic [31:0] e_top;
        logic        e_pv;
        logic [31:0] e_pd;
        logic        e_ovf, e_udf;
    } vec_t;

    vec_t tbl[18];

    initial begin
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'hAAAA, 0, 32'h0,  1'b0, 32'h0,    1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'hAAAA, 0, 32'h0,  1'b0, 32'h0,    1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h40,   1, 32'h40, 1'b0, 32'h0,    1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h80,   2, 32'h80, 1'b0, 32'h0,    1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'hC0,   3, 32'hC0, 1'b0, 32'h0,    1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,    2, 32'h80, 1'b1, 32'hC0,   1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,    1, 32'h40, 1'b1, 32'h80,   1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,    0, 32'h0,  1'b1, 32'h40,   1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,    0, 32'h0,  1'b0, 32'h40,   1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,    0, 32'h0,  1'b0, 32'h40,   1'b0, 1'b1};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0,    0, 32'h0,  1'b0, 32'h40,   1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h1234, 0, 32'h0,  1'b1, 32'h1234, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h10,   1, 32'h10, 1'b0, 32'h1234, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h20,   2, 32'h20, 1'b0, 32'h1234, 1'b0, 1'b0};
        tbl[14] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h30,   2, 32'h30, 1'b1, 32'h20,   1'b0, 1'b0};
        tbl[15] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,    1, 32'h10, 1'b1, 32'h30,   1'b0, 1'b0};
        tbl[16] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,    0, 32'h0,  1'b1, 32'h10,   1'b0, 1'b0};
        tbl[17] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h0,    0, 32'h0,  1'b0, 32'h10,   1'b0, 1'b1};

        for (int i = 0; i < 18; i++) begin
            step(tbl[i].r, tbl[i].p, tbl[i].q, tbl[i].d, tbl[i].c);
            chk($sformatf("v%0d_count", i), 32'(count), 32'(tbl[i].e_cnt));
            chk($sformatf("v%0d_top", i), top, tbl[i].e_top);
            chk($sformatf("v%0d_pv", i), 32'(pop_valid), 32'(tbl[i].e_pv));
            chk($sformatf("v%0d_pd", i), pop_data, tbl[i].e_pd);
            chk($sformatf("v%0d_ovf", i), 32'(overflow), 32'(tbl[i].e_ovf));
            chk($sformatf("v%0d_udf", i), 32'(underflow), 32'(tbl[i].e_udf));
            chk($sformatf("v%0d_empty", i), 32'(empty), 32'(tbl[i].e_cnt == 0));
        end

        // fill to full, overflow, clear, replace at full, clear racing a new overflow
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, 1'b0, 32'h100 + 32'(i), 1'b0);
        chk("full_after_16", 32'(full), 32'd1);
        step(1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_top_kept", top, 32'h10F);
        chk("ovf_count", 32'(count), 32'd16);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("ovf_cleared", 32'(overflow), 32'd0);
        step(1'b1, 1'b1, 1'b1, 32'h77, 1'b0);
        chk("repl_full_pd", pop_data, 32'h10F);
        chk("repl_full_no_ovf", 32'(overflow), 32'd0);
        step(1'b1, 1'b1, 1'b0, 32'h99, 1'b1);
        chk("ovf_set_beats_clr", 32'(overflow), 32'd1);
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b1, 32'h0, 1'b0);
        chk("drained_empty", 32'(empty), 32'd1);
        chk("drained_last_pd", pop_data, 32'h100);

        // reset landing on a pop
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 32'hA0 + 32'(i), 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
        chk("rst_pop_pv", 32'(pop_valid), 32'd0);
        chk("rst_pop_count", 32'(count), 32'd0);
        step(1'b1, 1'b1, 1'b0, 32'h55, 1'b0);
        chk("post_rst_top", top, 32'h55);
        chk("post_rst_count", 32'(count), 32'd1);

        // random traffic against the model
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 49) != 0, 1'($urandom), 1'($urandom),
                 $urandom, $urandom_range(0, 7) == 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/stack_unit.md
# stack_unit

Hardware LIFO return stack serving the push/pop requests issued by the decode stage's control unit (gated `push_out`/`pop_out`). Push stores the 32-bit return address from the execute path. Pop delivers the saved word one cycle later for use as the next PC source. It sits beside the data memory in the MEM stage and is the responder end of the decode stage's push/pop interface.

## Interface
Parameters:
- DATA_WIDTH, 32, width of each stack entry
- DEPTH, 16, number of entries; power of two, at least 2
- PTR_WIDTH, $clog2(DEPTH)+1, width of `count`

Ports:
- clk  in  1  clock; everything is rising-edge
- rst  in  1  reset; synchronous, active-low
- push  in  1  push request, sampled each cycle
- pop  in  1  pop request, sampled each cycle
- push_data  in  DATA_WIDTH  word to store on push
- clr_err  in  1  clears the sticky error flags
- pop_data  out  DATA_WIDTH  registered popped word
- pop_valid  out  1  one-cycle pulse; `pop_data` is valid this cycle
- top  out  DATA_WIDTH  combinational peek of the current top entry; 0 when empty
- count  out  PTR_WIDTH  number of occupied entries, 0..DEPTH
- empty  out  1  high when `count` is 0
- full  out  1  high when `count` equals DEPTH
- overflow  out  1  sticky; set by a push that was dropped
- underflow  out  1  sticky; set by a pop that was rejected

## Operation
- Storage is DEPTH×DATA_WIDTH. `sp` = `count`. The top entry is `mem[sp-1]`.
- Modes are derived from `count`: EMPTY (count is 0), PARTIAL, FULL (count is DEPTH). There is no separate state register.

Per-cycle action, first matching row wins:
- push=0, pop=0: no change. `pop_valid` is 0.
- push=1, pop=0, not full: `mem[sp]` ← push_data; count+1.
- push=1, pop=0, full: push is dropped; `overflow` ← 1; memory and count unchanged.
- push=0, pop=1, not empty: `pop_data` ← `mem[sp-1]`; `pop_valid` ← 1; count−1. The stale entry is not cleared.
- push=0, pop=1, empty: `underflow` ← 1; `pop_valid` ← 0; `pop_data` holds its previous value.
- push=1, pop=1, not empty (includes full): replace top. `pop_data` ← old `mem[sp-1]`; `mem[sp-1]` ← push_data; `pop_valid` ← 1; count unchanged. No overflow is flagged.
- push=1, pop=1, empty: pass-through. `pop_data` ← push_data; `pop_valid` ← 1; count stays 0; memory unchanged.

Error flags:
- `clr_err`=1 clears `overflow` and `underflow`.
- If `clr_err` coincides with a new error event, the set wins.

Width rule:
- `count` never wraps. The increment/decrement guards above are the only way it changes.

## Timing
- Reset (rst=0 at an edge) forces: count=0, pop_data=0, pop_valid=0, overflow=0, underflow=0. Therefore empty=1, full=0, top=0.
- Memory contents are not reset.
- Reset overrides any push or pop in the same cycle. A request in flight during reset is lost.
- Pop latency is 1 cycle: request at edge N gives `pop_data`/`pop_valid` after edge N, and `pop_valid` drops after edge N+1 unless another pop is accepted.
- Push is visible on `top` and `count` after the same edge.
- Back-to-back push or pop every cycle is supported at full throughput. There are no stalls or backpressure.
- `empty`, `full` and `top` are combinational from the `count` register and the memory.

## Structure
- Shared package `musa_pkg`: `WORD_W`=32, default stack depth constant, and a typedef `word_t`.
- One sub-module, `stack_ram`: DEPTH×DATA_WIDTH, one synchronous write port, one asynchronous read port addressed by `sp-1`.
- `stack_unit` holds the count register, the request decode, the output registers and the error flags.

## Test plan
- **Reset:** rst=0 for 2 cycles with push=1 → count=0, empty=1, pop_valid=0, top=0, no write has occurred.
- **Push then pop:** push 0x0000_0040, 0x0000_0080, 0x0000_00C0 → count=3, top=0xC0. Then three pops → pop_data is 0xC0, 0x80, 0x40 on consecutive cycles, pop_valid high for 3 cycles, then empty=1.
- **Full/overflow:** DEPTH=16; push 16 words → full=1. A 17th push of 0xDEAD_BEEF → overflow=1, count=16, top unchanged. Then clr_err → overflow=0.
- **Empty/underflow:** pop on empty → underflow=1, pop_valid=0, pop_data keeps its last value. Then push=1, pop=1 on empty with 0x1234 → pop_data=0x1234, pop_valid=1, count=0.
- **Replace top:** stack holds [0x10, 0x20]; push=1, pop=1 with 0x30 → pop_data=0x20, top=0x30, count=2. Repeat the same at full → no overflow.
- **Reset mid-sequence:** 5 pushes, then rst=0 coinciding with a pop → pop_valid=0, count=0 after the edge. A following push of 0x55 → top=0x55, count=1.
